// File: rtl/fir_sample_sequencer.sv
//------------------------------------------------------------------------------
// Module   : fir_sample_sequencer
// Brief    : Sample FIFO feeding a time-multiplexed FIR; presents samples on the
//            FIR capture phase, flags fresh results. Option: FIR_SEQ_FREERUN_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_sample_sequencer #(
    parameter int WIDTH = 24,
    parameter int TAPS  = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           fir_sig,
    output logic                       fir_ready,
    output logic                       result_stb,
    output logic                       underrun,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(TAPS);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [PW-1:0] c_PHASE_LAST = PW'(TAPS - 1);
    localparam logic [LW-1:0] c_LEVEL_FULL = LW'(DEPTH);

    logic             r_en;
    logic [PW-1:0]    r_phase;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_primed;
    logic             r_stb;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_at_end;
    logic w_fir_ready;
    logic w_capture;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == c_LEVEL_FULL);
    assign w_at_end = (r_phase == c_PHASE_LAST);

`ifdef FIR_SEQ_FREERUN_EN
    assign w_fir_ready = r_en;
`else
    // Hold the FIR on its capture phase until a real sample is available.
    assign w_fir_ready = r_en && (!w_at_end || !w_empty);
`endif

    assign w_capture = w_fir_ready && w_at_end;
    assign w_pop     = w_capture && !w_empty;
    assign w_push    = s_valid && !w_full;

    assign s_ready    = !w_full;
    assign fir_ready  = w_fir_ready;
    assign fir_sig    = w_empty ? '0 : r_mem[r_rptr];
    assign result_stb = r_stb;
    assign level      = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_phase  <= c_PHASE_LAST;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_primed <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (w_fir_ready) begin
                r_phase <= r_phase + PW'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            // The first capture after reset yields the FIR's stale accumulator.
            if (w_capture) begin
                r_stb    <= r_primed;
                r_primed <= 1'b1;
            end else begin
                r_stb    <= 1'b0;
            end
        end
    end

`ifdef FIR_SEQ_FREERUN_EN
    logic r_underrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_capture && w_empty) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_fir_sample_sequencer
// Brief    : Self-checking bench with a queue-based reference of the sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_sample_sequencer;

    localparam int WIDTH = 24;
    localparam int TAPS  = 128;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data  = '0;
    logic             s_ready;
    logic [WIDTH-1:0] fir_sig;
    logic             fir_ready;
    logic             result_stb;
    logic             underrun;
    logic [LW-1:0]    level;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: enable, tap phase, FIFO contents, result bookkeeping.
    bit               m_en;
    bit               m_primed;
    bit               m_stb;
    bit               m_under;
    int               m_phase;
    logic [WIDTH-1:0] m_q[$];

    fir_sample_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .fir_sig    (fir_sig),
        .fir_ready  (fir_ready),
        .result_stb (result_stb),
        .underrun   (underrun),
        .level      (level)
    );

    always #5 clk = ~clk;

    function automatic bit m_fir_ready();
`ifdef FIR_SEQ_FREERUN_EN
        return m_en;
`else
        return m_en && (m_phase != TAPS - 1 || m_q.size() != 0);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] m_fir_sig();
        logic [WIDTH-1:0] v;
        v = '0;
        if (m_q.size() != 0) v = m_q[0];
        return v;
    endfunction

    function automatic logic [LW-1:0] m_level();
        return LW'(m_q.size());
    endfunction

    task automatic model_reset();
        m_en     = 1'b0;
        m_primed = 1'b0;
        m_stb    = 1'b0;
        m_under  = 1'b0;
        m_phase  = TAPS - 1;
        m_q.delete();
    endtask

    task automatic model_edge();
        bit fr;
        bit cap;
        bit push;
        fr   = m_fir_ready();
        cap  = fr && (m_phase == TAPS - 1);
        push = s_valid && (m_q.size() < DEPTH);
        if (cap) begin
            m_stb    = m_primed;
            m_primed = 1'b1;
            if (m_q.size() == 0) begin
`ifdef FIR_SEQ_FREERUN_EN
                m_under = 1'b1;
`endif
            end else begin
                void'(m_q.pop_front());
            end
        end else begin
            m_stb = 1'b0;
        end
        if (push) m_q.push_back(s_data);
        if (fr) m_phase = (m_phase + 1) % TAPS;
        m_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_chk += 6;
        if (fir_ready !== 1'b0) begin n_err++; $display("FAIL reset.fir_ready got=%b exp=0", fir_ready); end
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset.s_ready got=%b exp=1", s_ready); end
        if (level !== '0) begin n_err++; $display("FAIL reset.level got=%0d exp=0", level); end
        if (result_stb !== 1'b0) begin n_err++; $display("FAIL reset.result_stb got=%b exp=0", result_stb); end
        if (fir_sig !== '0) begin n_err++; $display("FAIL reset.fir_sig got=%h exp=0", fir_sig); end
        if (underrun !== 1'b0) begin n_err++; $display("FAIL reset.underrun got=%b exp=0", underrun); end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk += 4;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL idle.fir_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (level !== '0) begin n_err++; $display("FAIL idle.level cyc=%0d got=%0d exp=0", i, level); end
            if (result_stb !== 1'b0) begin n_err++; $display("FAIL idle.result_stb cyc=%0d got=%b exp=0", i, result_stb); end
            if (s_ready !== 1'b1) begin n_err++; $display("FAIL idle.s_ready cyc=%0d got=%b exp=1", i, s_ready); end
        end
    endtask

    task automatic test_single();
        int stb_cnt;
        int cap_cnt;
        stb_cnt = 0;
        cap_cnt = 0;
        do_reset();
        s_valid = 1'b1;
        s_data  = 24'h000100;
        tick();
        s_valid = 1'b0;
        n_chk++;
        if (fir_sig !== 24'h000100) begin n_err++; $display("FAIL single.visible got=%h exp=000100", fir_sig); end
        for (int i = 0; i < 2 * TAPS + 10; i++) begin
            if (i == TAPS + 3) begin
                s_valid = 1'b1;
                s_data  = WIDTH'($urandom);
            end else begin
                s_valid = 1'b0;
            end
            n_chk += 4;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL single.fir_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (fir_sig !== m_fir_sig()) begin n_err++; $display("FAIL single.fir_sig cyc=%0d got=%h exp=%h", i, fir_sig, m_fir_sig()); end
            if (result_stb !== m_stb) begin n_err++; $display("FAIL single.result_stb cyc=%0d got=%b exp=%b", i, result_stb, m_stb); end
            if (level !== m_level()) begin n_err++; $display("FAIL single.level cyc=%0d got=%0d exp=%0d", i, level, m_level()); end
            if (result_stb === 1'b1) stb_cnt++;
            if (fir_ready === 1'b1 && m_phase == TAPS - 1) cap_cnt++;
            tick();
        end
        s_valid = 1'b0;
`ifndef FIR_SEQ_FREERUN_EN
        n_chk += 2;
        if (cap_cnt != 2) begin n_err++; $display("FAIL single.captures got=%0d exp=2", cap_cnt); end
        if (stb_cnt != 1) begin n_err++; $display("FAIL single.stb_count got=%0d exp=1", stb_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pushed[$];
        logic [WIDTH-1:0] caps[$];
        int               cap_cyc[$];
        logic [WIDTH-1:0] d;
        int               stb_cnt;
        bit               saw_full;
        bit               acc;
        stb_cnt  = 0;
        saw_full = 1'b0;
        do_reset();
        s_data  = WIDTH'($urandom);
        s_valid = 1'b1;
        for (int i = 0; i < 9 * TAPS; i++) begin
            n_chk += 5;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL b2b.fir_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (fir_sig !== m_fir_sig()) begin n_err++; $display("FAIL b2b.fir_sig cyc=%0d got=%h exp=%h", i, fir_sig, m_fir_sig()); end
            if (level !== m_level()) begin n_err++; $display("FAIL b2b.level cyc=%0d got=%0d exp=%0d", i, level, m_level()); end
            if (s_ready !== (m_q.size() < DEPTH)) begin n_err++; $display("FAIL b2b.s_ready cyc=%0d got=%b exp=%b", i, s_ready, (m_q.size() < DEPTH)); end
            if (result_stb !== m_stb) begin n_err++; $display("FAIL b2b.result_stb cyc=%0d got=%b exp=%b", i, result_stb, m_stb); end
            if (s_ready === 1'b0) saw_full = 1'b1;
            if (result_stb === 1'b1) stb_cnt++;
            if (fir_ready === 1'b1 && m_phase == TAPS - 1) begin
                caps.push_back(fir_sig);
                cap_cyc.push_back(i);
            end
            acc = s_valid && (m_q.size() < DEPTH);
            d   = s_data;
            tick();
            if (acc) begin
                pushed.push_back(d);
                if (pushed.size() == 8) s_valid = 1'b0;
                else s_data = WIDTH'($urandom);
            end
        end
        s_valid = 1'b0;
        n_chk++;
        if (!saw_full) begin n_err++; $display("FAIL b2b.full_backpressure got=0 exp=1"); end
`ifndef FIR_SEQ_FREERUN_EN
        n_chk += 2;
        if (stb_cnt != 7) begin n_err++; $display("FAIL b2b.stb_count got=%0d exp=7", stb_cnt); end
        if (caps.size() != 8) begin n_err++; $display("FAIL b2b.capture_count got=%0d exp=8", caps.size()); end
        for (int k = 0; k < caps.size() && k < pushed.size(); k++) begin
            n_chk++;
            if (caps[k] !== pushed[k]) begin n_err++; $display("FAIL b2b.order idx=%0d got=%h exp=%h", k, caps[k], pushed[k]); end
        end
        for (int k = 1; k < cap_cyc.size(); k++) begin
            n_chk++;
            if (cap_cyc[k] - cap_cyc[k-1] != TAPS) begin n_err++; $display("FAIL b2b.spacing idx=%0d got=%0d exp=%0d", k, cap_cyc[k] - cap_cyc[k-1], TAPS); end
        end
`endif
    endtask

    task automatic test_simul_push_pop();
        logic [WIDTH-1:0] a, b, c, d;
        int g;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = WIDTH'($urandom);
        d = WIDTH'($urandom);
        do_reset();
        s_valid = 1'b1;
        s_data  = a;
        tick();
        s_data = b;
        tick();
        s_data = c;
        tick();
        s_valid = 1'b0;
`ifndef FIR_SEQ_FREERUN_EN
        n_chk++;
        if (level !== LW'(2)) begin n_err++; $display("FAIL simul.setup_level got=%0d exp=2", level); end
`endif
        g = 0;
        while (m_phase != TAPS - 1 && g < 2 * TAPS) begin
            tick();
            g++;
        end
        n_chk++;
        if (g >= 2 * TAPS) begin n_err++; $display("FAIL simul.timeout got=%0d exp<%0d", g, 2 * TAPS); end
`ifndef FIR_SEQ_FREERUN_EN
        n_chk += 2;
        if (fir_ready !== 1'b1) begin n_err++; $display("FAIL simul.capture_ready got=%b exp=1", fir_ready); end
        if (fir_sig !== b) begin n_err++; $display("FAIL simul.capture_sig got=%h exp=%h", fir_sig, b); end
`endif
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
`ifndef FIR_SEQ_FREERUN_EN
        n_chk += 2;
        if (level !== LW'(2)) begin n_err++; $display("FAIL simul.level got=%0d exp=2", level); end
        if (fir_sig !== c) begin n_err++; $display("FAIL simul.next_sig got=%h exp=%h", fir_sig, c); end
`endif
        n_chk++;
        if (level !== m_level()) begin n_err++; $display("FAIL simul.model_level got=%0d exp=%0d", level, m_level()); end
    endtask

    task automatic test_random();
        int rate;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rate    = (i < 700) ? 150 : 3;
            s_valid = ($urandom_range(0, rate) == 0);
            s_data  = WIDTH'($urandom);
            n_chk += 6;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL rand.fir_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (fir_sig !== m_fir_sig()) begin n_err++; $display("FAIL rand.fir_sig cyc=%0d got=%h exp=%h", i, fir_sig, m_fir_sig()); end
            if (level !== m_level()) begin n_err++; $display("FAIL rand.level cyc=%0d got=%0d exp=%0d", i, level, m_level()); end
            if (s_ready !== (m_q.size() < DEPTH)) begin n_err++; $display("FAIL rand.s_ready cyc=%0d got=%b exp=%b", i, s_ready, (m_q.size() < DEPTH)); end
            if (result_stb !== m_stb) begin n_err++; $display("FAIL rand.result_stb cyc=%0d got=%b exp=%b", i, result_stb, m_stb); end
            if (underrun !== m_under) begin n_err++; $display("FAIL rand.underrun cyc=%0d got=%b exp=%b", i, underrun, m_under); end
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int g;
        do_reset();
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = WIDTH'($urandom);
            tick();
        end
        s_valid = 1'b0;
        g = 0;
        while (m_phase != 40 && g < 2 * TAPS) begin
            tick();
            g++;
        end
        n_chk += 2;
        if (g >= 2 * TAPS) begin n_err++; $display("FAIL midrst.timeout got=%0d exp<%0d", g, 2 * TAPS); end
`ifndef FIR_SEQ_FREERUN_EN
        if (level !== LW'(3)) begin n_err++; $display("FAIL midrst.setup_level got=%0d exp=3", level); end
`else
        if (level !== m_level()) begin n_err++; $display("FAIL midrst.setup_level got=%0d exp=%0d", level, m_level()); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_chk += 6;
        if (fir_ready !== 1'b0) begin n_err++; $display("FAIL midrst.fir_ready got=%b exp=0", fir_ready); end
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL midrst.s_ready got=%b exp=1", s_ready); end
        if (level !== '0) begin n_err++; $display("FAIL midrst.level got=%0d exp=0", level); end
        if (result_stb !== 1'b0) begin n_err++; $display("FAIL midrst.result_stb got=%b exp=0", result_stb); end
        if (fir_sig !== '0) begin n_err++; $display("FAIL midrst.fir_sig got=%h exp=0", fir_sig); end
        if (underrun !== 1'b0) begin n_err++; $display("FAIL midrst.underrun got=%b exp=0", underrun); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < TAPS + 20; i++) begin
            s_valid = (i == 5);
            s_data  = WIDTH'($urandom);
            n_chk += 4;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL midrst.post_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (fir_sig !== m_fir_sig()) begin n_err++; $display("FAIL midrst.post_sig cyc=%0d got=%h exp=%h", i, fir_sig, m_fir_sig()); end
            if (level !== m_level()) begin n_err++; $display("FAIL midrst.post_level cyc=%0d got=%0d exp=%0d", i, level, m_level()); end
            if (result_stb !== m_stb) begin n_err++; $display("FAIL midrst.post_stb cyc=%0d got=%b exp=%b", i, result_stb, m_stb); end
            tick();
        end
        s_valid = 1'b0;
    endtask

`ifdef FIR_SEQ_FREERUN_EN
    task automatic test_freerun();
        int cap_cyc[$];
        do_reset();
        for (int i = 0; i < 3 * TAPS + 8; i++) begin
            n_chk += 3;
            if (fir_ready !== m_fir_ready()) begin n_err++; $display("FAIL free.fir_ready cyc=%0d got=%b exp=%b", i, fir_ready, m_fir_ready()); end
            if (fir_sig !== '0) begin n_err++; $display("FAIL free.fir_sig cyc=%0d got=%h exp=0", i, fir_sig); end
            if (underrun !== m_under) begin n_err++; $display("FAIL free.underrun cyc=%0d got=%b exp=%b", i, underrun, m_under); end
            if (fir_ready === 1'b1 && m_phase == TAPS - 1) cap_cyc.push_back(i);
            tick();
        end
        n_chk += 2;
        if (underrun !== 1'b1) begin n_err++; $display("FAIL free.underrun_sticky got=%b exp=1", underrun); end
        if (cap_cyc.size() < 3) begin n_err++; $display("FAIL free.capture_count got=%0d exp>=3", cap_cyc.size()); end
        for (int k = 1; k < cap_cyc.size(); k++) begin
            n_chk++;
            if (cap_cyc[k] - cap_cyc[k-1] != TAPS) begin n_err++; $display("FAIL free.spacing idx=%0d got=%0d exp=%0d", k, cap_cyc[k] - cap_cyc[k-1], TAPS); end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_simul_push_pop();
        test_random();
        test_mid_reset();
`ifdef FIR_SEQ_FREERUN_EN
        test_freerun();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
